dma_bus_arbiter: RTL and testbench

Cycle-level owner of the CPU-side system bus in the APU wrapper. Arbitrates between the 6502 core, OAM sprite DMA triggered by a CPU write to $4014, and single-byte DMC sample fetches. Halts the CPU only on read cycles and aligns each DMA transfer to the get/put cycle parity. Its outputs drive the system bus directly; `cpu_halt` is ANDed into the core's READY.

---
 rtl/dma_bus_arbiter_if.sv | 27 ++
 rtl/dma_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_dma_bus_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_bus_arbiter_if.sv
// Bus bundle for dma_bus_arbiter: core-side request, system bus and DMC fetch port.
// The master modport is the arbiter's view; slave is the surrounding wrapper's view.
interface dma_bus_arbiter_if;
    logic [15:0] cpu_addr_i;
    logic [7:0]  cpu_data_i;
    logic        cpu_rw_i;
    logic [7:0]  bus_data_i;
    logic [15:0] addr_o;
    logic [7:0]  data_o;
    logic        rw_o;
    logic        cpu_halt;
    logic        oam_busy;
    logic        dmc_req;
    logic [15:0] dmc_addr_i;
    logic        dmc_ack;
    logic [7:0]  dmc_data_o;

    modport master (
        input  cpu_addr_i, cpu_data_i, cpu_rw_i, bus_data_i, dmc_req, dmc_addr_i,
        output addr_o, data_o, rw_o, cpu_halt, oam_busy, dmc_ack, dmc_data_o
    );

    modport slave (
        output cpu_addr_i, cpu_data_i, cpu_rw_i, bus_data_i, dmc_req, dmc_addr_i,
        input  addr_o, data_o, rw_o, cpu_halt, oam_busy, dmc_ack, dmc_data_o
    );
endinterface

// File: rtl/dma_bus_arbiter.sv
// CPU-side bus owner: arbitrates the 6502 core, OAM sprite DMA ($4014) and DMC sample fetches.
// Define DMC_DMA_EN to include the DMC fetch path; without it only OAM DMA is built.
module dma_bus_arbiter (
    input  logic              clk,
    input  logic              rst,
    dma_bus_arbiter_if.master bus
);
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
    localparam logic [15:0] OAM_TRIG_ADDR = 16'h4014;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HALT   = 3'd1,
        ALIGN  = 3'd2,
        OAM_RD = 3'd3,
        OAM_WR = 3'd4
`ifdef DMC_DMA_EN
        ,
        DMC_RD  = 3'd5,
        DMC_CAP = 3'd6
`endif
    } state_t;

    state_t     state;
    state_t     state_nxt;
    state_t     xfer_entry;
    logic       put;
    logic       oam_pend;
    logic       dmc_pend;
    logic       any_pend;
    logic       oam_trig;
    logic [7:0] page;
    logic [7:0] idx;

`ifdef DMC_DMA_EN
    assign dmc_pend = bus.dmc_req && (state != DMC_RD) && (state != DMC_CAP);
`else
    logic unused_dmc;
    assign unused_dmc = ^{bus.dmc_req, bus.dmc_addr_i};
    assign dmc_pend   = 1'b0;
`endif

    assign any_pend = dmc_pend || oam_pend;
    assign oam_trig = (state == IDLE) && !bus.cpu_rw_i && (bus.cpu_addr_i == OAM_TRIG_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Get/put parity, OAM source page and byte index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            put      <= 1'b0;
            oam_pend <= 1'b0;
            idx      <= 8'h00;
            page     <= 8'h00;
        end else begin
            put <= ~put;
            if (oam_trig) begin
                page     <= bus.cpu_data_i;
                idx      <= 8'h00;
                oam_pend <= 1'b1;
            end else if (state == OAM_WR) begin
                idx <= idx + 8'd1;
                if (idx == 8'hFF) begin
                    oam_pend <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        xfer_entry = IDLE;
        if (oam_pend) begin
            xfer_entry = OAM_RD;
        end
`ifdef DMC_DMA_EN
        if (dmc_pend) begin
            xfer_entry = DMC_RD;
        end
`endif
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_pend && bus.cpu_rw_i) begin
                    state_nxt = HALT;
                end
            end
            HALT:   state_nxt = put ? xfer_entry : ALIGN;
            ALIGN:  state_nxt = xfer_entry;
            OAM_RD: state_nxt = OAM_WR;
            OAM_WR: begin
                if (oam_pend && (idx != 8'hFF)) begin
                    state_nxt = OAM_RD;
                end else begin
                    state_nxt = IDLE;
                end
`ifdef DMC_DMA_EN
                if (dmc_pend) begin
                    state_nxt = DMC_RD;
                end
`endif
            end
`ifdef DMC_DMA_EN
            DMC_RD:  state_nxt = DMC_CAP;
            DMC_CAP: state_nxt = oam_pend ? OAM_RD : IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Bus drive; everything outside a transfer passes the core through.
    always_comb begin
        bus.addr_o     = bus.cpu_addr_i;
        bus.data_o     = bus.cpu_data_i;
        bus.rw_o       = bus.cpu_rw_i;
        bus.dmc_ack    = 1'b0;
        bus.dmc_data_o = 8'h00;
        case (state)
            HALT, ALIGN: begin
                bus.rw_o = 1'b1;
            end
            OAM_RD: begin
                bus.addr_o = {page, idx};
                bus.rw_o   = 1'b1;
            end
            OAM_WR: begin
                bus.addr_o = OAM_DATA_ADDR;
                bus.rw_o   = 1'b0;
                bus.data_o = bus.bus_data_i;
            end
`ifdef DMC_DMA_EN
            DMC_RD: begin
                bus.addr_o = bus.dmc_addr_i;
                bus.rw_o   = 1'b1;
            end
            DMC_CAP: begin
                bus.addr_o     = bus.dmc_addr_i;
                bus.rw_o       = 1'b1;
                bus.dmc_ack    = 1'b1;
                bus.dmc_data_o = bus.bus_data_i;
            end
`endif
            default: begin
            end
        endcase
        bus.cpu_halt = !rst && ((state != IDLE) || (any_pend && bus.cpu_rw_i));
        bus.oam_busy = oam_pend;
    end
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter: randomized OAM/DMC DMA runs against a
// transaction-level model of the expected bus cycles and halt lengths.
module tb_dma_bus_arbiter;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
    localparam logic [15:0] OAM_TRIG_ADDR = 16'h4014;

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  data;
        int          cyc;
        logic        busy;
    } bus_cycle_t;

    logic clk = 1'b0;
    logic rst;

    dma_bus_arbiter_if bus_if ();

    dma_bus_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int          check_count = 0;
    int          pass_count  = 0;
    int          cyc;
    logic        last_halt;
    int          ack_count;
    int          ack_cyc;
    logic [7:0]  ack_data;
    logic [15:0] sampled_addr;
    logic        sampled_rd;
    bus_cycle_t  obs_q[$];
    bus_cycle_t  exp_q[$];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Memory contents seen by the bus; $C123 holds the known DMC sample.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        logic [7:0] t;
        if (a == 16'hC123) begin
            return 8'h5A;
        end
        t = a[7:0] * 8'd37;
        return t ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [15:0] randCpuAddr();
        return 16'h8000 | 16'($urandom_range(0, 16'h3FFF));
    endfunction

    function automatic logic [15:0] randDmcAddr();
        return 16'hC000 | 16'($urandom_range(0, 16'h3FFF));
    endfunction

    // One clock: sample at the falling edge, then answer the previous read after the rising edge.
    task automatic tick();
        bus_cycle_t c;
        @(negedge clk);
        last_halt = bus_if.cpu_halt;
        if (bus_if.addr_o !== bus_if.cpu_addr_i || bus_if.rw_o !== bus_if.cpu_rw_i) begin
            c.addr = bus_if.addr_o;
            c.rw   = bus_if.rw_o;
            c.data = bus_if.data_o;
            c.cyc  = cyc;
            c.busy = bus_if.oam_busy;
            obs_q.push_back(c);
        end
        if (bus_if.dmc_ack === 1'b1) begin
            ack_count++;
            ack_cyc  = cyc;
            ack_data = bus_if.dmc_data_o;
            bus_if.dmc_req = 1'b0;
        end
        sampled_addr = bus_if.addr_o;
        sampled_rd   = bus_if.rw_o;
        @(posedge clk);
        cyc++;
        #1;
        bus_if.bus_data_i = sampled_rd ? mem_byte(sampled_addr) : 8'h00;
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data, input logic rw);
        bus_if.cpu_addr_i = addr;
        bus_if.cpu_data_i = data;
        bus_if.cpu_rw_i   = rw;
        tick();
    endtask

    task automatic pushCycle(input logic [15:0] addr, input logic rw, input logic [7:0] data);
        bus_cycle_t e;
        e.addr = addr;
        e.rw   = rw;
        e.data = data;
        e.cyc  = 0;
        e.busy = 1'b0;
        exp_q.push_back(e);
    endtask

    // Runs one DMA episode. dmc_at < 0 raises the DMC request together with the trigger
    // (or alone when do_oam=0); otherwise it is raised while OAM byte dmc_at is in flight.
    task automatic runDma(input logic do_oam, input logic [7:0] page, input logic do_dmc,
                          input int dmc_at, input logic halt_on_put, input int n_defer,
                          input logic [15:0] dmc_addr);
        bus_cycle_t e;
        int         req_cyc;
        int         halted;
        int         guard;
        int         first_cyc;
        int         ack_slot;
        int         fails_before;
        logic       armed;
        obs_q.delete();
        exp_q.delete();
        ack_count = 0;
        ack_slot  = -1;
        armed     = 1'b0;
        bus_if.cpu_addr_i = randCpuAddr();
        bus_if.cpu_rw_i   = 1'b0;
        if (do_dmc && (dmc_at < 0 || !do_oam)) begin
            bus_if.dmc_addr_i = dmc_addr;
            bus_if.dmc_req    = 1'b1;
        end
        if (do_oam) begin
            applyStimulus(OAM_TRIG_ADDR, page, 1'b0);
            checkOutput("oam_busy_set", bus_if.oam_busy, 1'b1);
        end
        for (int i = 0; i < n_defer; i++) begin
            applyStimulus(randCpuAddr(), 8'($urandom), 1'b0);
            checkOutput("defer_halt", last_halt, 1'b0);
        end
        if (((cyc % 2) == 0) != halt_on_put) begin
            applyStimulus(randCpuAddr(), 8'($urandom), 1'b0);
            checkOutput("defer_halt", last_halt, 1'b0);
        end
        checkOutput("defer_no_dma", obs_q.size(), 0);

        req_cyc = cyc;
        bus_if.cpu_addr_i = randCpuAddr();
        bus_if.cpu_data_i = 8'($urandom);
        bus_if.cpu_rw_i   = 1'b1;
        halted = 0;
        guard  = 0;
        do begin
            tick();
            if (last_halt) halted++;
            guard++;
            if (do_dmc && do_oam && dmc_at >= 0 && !armed && obs_q.size() > 0) begin
                e = obs_q[$];
                if (e.rw && e.addr == {page, 8'(dmc_at)} && e.cyc == cyc - 1) begin
                    bus_if.dmc_addr_i = dmc_addr;
                    bus_if.dmc_req    = 1'b1;
                    armed             = 1'b1;
                end
            end
        end while (last_halt && guard < 2000);
        checkOutput("halt_timeout", guard >= 2000, 1'b0);

        if (do_dmc && (dmc_at < 0 || !do_oam)) begin
            ack_slot = exp_q.size() + 1;
            pushCycle(dmc_addr, 1'b1, 8'h00);
            pushCycle(dmc_addr, 1'b1, 8'h00);
        end
        if (do_oam) begin
            for (int i = 0; i < 256; i++) begin
                pushCycle({page, 8'(i)}, 1'b1, 8'h00);
                pushCycle(OAM_DATA_ADDR, 1'b0, mem_byte({page, 8'(i)}));
                if (do_dmc && i == dmc_at) begin
                    ack_slot = exp_q.size() + 1;
                    pushCycle(dmc_addr, 1'b1, 8'h00);
                    pushCycle(dmc_addr, 1'b1, 8'h00);
                end
            end
        end

        // The request cycle where READY first drops is excluded; the count starts at the HALT read.
        checkOutput("halt_len", halted - 1,
                    1 + (halt_on_put ? 0 : 1) + (do_dmc ? 2 : 0) + (do_oam ? 512 : 0));

        first_cyc = req_cyc + (halt_on_put ? 2 : 3);
        checkOutput("dma_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            fails_before = check_count - pass_count;
            checkOutput("dma_cycle",
                        {16'(obs_q[i].cyc - first_cyc), obs_q[i].addr, obs_q[i].rw,
                         obs_q[i].rw ? 8'h00 : obs_q[i].data},
                        {16'(i), exp_q[i].addr, exp_q[i].rw, exp_q[i].data});
            if (check_count - pass_count != fails_before) break;
        end
        if (do_oam && obs_q.size() > 0) begin
            checkOutput("busy_last_wr", obs_q[$].busy, 1'b1);
        end
        checkOutput("busy_clear", bus_if.oam_busy, 1'b0);
        checkOutput("ack_count", ack_count, do_dmc ? 1 : 0);
        if (do_dmc) begin
            checkOutput("ack_cycle", ack_cyc - first_cyc, ack_slot);
            checkOutput("ack_data", ack_data, mem_byte(dmc_addr));
        end
    endtask

    task automatic resetMidOam(input logic [7:0] page);
        int guard;
        int halts;
        obs_q.delete();
        applyStimulus(OAM_TRIG_ADDR, page, 1'b0);
        bus_if.cpu_addr_i = randCpuAddr();
        bus_if.cpu_rw_i   = 1'b1;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!(obs_q.size() > 0 && obs_q[$].rw && obs_q[$].addr == {page, 8'h80}) && guard < 1000);
        checkOutput("mid_timeout", guard >= 1000, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_halt", bus_if.cpu_halt, 1'b0);
        checkOutput("mid_rst_busy", bus_if.oam_busy, 1'b0);
        checkOutput("mid_rst_addr", bus_if.addr_o, bus_if.cpu_addr_i);
        checkOutput("mid_rst_rw", bus_if.rw_o, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        cyc = 0;
        obs_q.delete();
        halts = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(randCpuAddr(), 8'($urandom), 1'b1);
            if (last_halt) halts++;
        end
        checkOutput("post_rst_dma", obs_q.size(), 0);
        checkOutput("post_rst_halt", halts, 0);
    endtask

    initial begin
        rst               = 1'b1;
        cyc               = 0;
        bus_if.cpu_addr_i = 16'h8123;
        bus_if.cpu_data_i = 8'hA5;
        bus_if.cpu_rw_i   = 1'b1;
        bus_if.bus_data_i = 8'h00;
        bus_if.dmc_req    = 1'b1;
        bus_if.dmc_addr_i = 16'hC000;
        #12;
        checkOutput("rst_addr", bus_if.addr_o, 16'h8123);
        checkOutput("rst_data", bus_if.data_o, 8'hA5);
        checkOutput("rst_rw", bus_if.rw_o, 1'b1);
        checkOutput("rst_halt", bus_if.cpu_halt, 1'b0);
        checkOutput("rst_busy", bus_if.oam_busy, 1'b0);
        checkOutput("rst_ack", bus_if.dmc_ack, 1'b0);
        bus_if.dmc_req = 1'b0;
        bus_if.cpu_rw_i = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        cyc = 0;

        runDma(1'b1, 8'h02, 1'b0, -1, 1'b1, 0, 16'h0000);
        runDma(1'b1, 8'h02, 1'b0, -1, 1'b0, 3, 16'h0000);
        for (int r = 0; r < 3; r++) begin
            runDma(1'b1, 8'($urandom_range(0, 127)), 1'b0, -1, 1'($urandom),
                   $urandom_range(0, 3), 16'h0000);
        end
`ifdef DMC_DMA_EN
        runDma(1'b0, 8'h00, 1'b1, -1, 1'b1, 0, 16'hC123);
        runDma(1'b0, 8'h00, 1'b1, -1, 1'b0, 1, randDmcAddr());
        runDma(1'b1, 8'($urandom_range(0, 127)), 1'b1, 8'h40, 1'($urandom), 0, randDmcAddr());
        runDma(1'b1, 8'($urandom_range(0, 127)), 1'b1, -1, 1'($urandom), 1, randDmcAddr());
`else
        bus_if.cpu_rw_i   = 1'b0;
        bus_if.dmc_addr_i = 16'hC123;
        bus_if.dmc_req    = 1'b1;
        runDma(1'b1, 8'h05, 1'b0, -1, 1'($urandom), 0, 16'h0000);
        checkOutput("dmc_off_data", bus_if.dmc_data_o, 8'h00);
        bus_if.dmc_req = 1'b0;
`endif
        resetMidOam(8'($urandom_range(0, 127)));

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
